// File: rtl/alu_control.sv
// alu_control
//
// ALU control decoder for the RV32 datapath. Combines the operation class
// from the main control unit with funct3/funct7 of the instruction word and
// produces a registered 2-bit ALU function select. Latency is one cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   instruccion  instruction word (funct3 = [14:12], funct7 = [31:25]);
//                bits above 31 are ignored
//   ALU_OP       operation class: 00 load/store, 01 branch, 10 R-type,
//                11 I-type arithmetic
//   valid_in     inputs are valid this cycle
//   alu_inst     registered function select: 00 ADD, 01 SUB, 10 AND, 11 OR
//   valid_out    alu_inst belongs to a valid_in sampled on the previous edge
//   illegal      registered unsupported funct3/funct7 flag
//
// Configuration:
//   ALU_CONTROL_ILLEGAL_DET_EN  when defined, illegal reports unsupported
//                               decodes; when undefined, illegal is tied to 0
//                               and its register/detection logic is absent.
//                               Unsupported combinations decode to ADD either way.

module alu_control #(
  parameter int width_instruc = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [width_instruc-1:0] instruccion,
  input  logic [1:0]               ALU_OP,
  input  logic                     valid_in,
  output logic [1:0]               alu_inst,
  output logic                     valid_out,
  output logic                     illegal
);

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  logic [2:0] funct3_p0;
  logic [6:0] funct7_p0;
  logic [1:0] sel_p0;
  logic [1:0] alu_inst_p1;
  logic       vld_p1;

  // Only funct3/funct7 matter; the remaining bits are folded here so the
  // full input port is consumed.
  logic unused_bits;
  assign unused_bits = ^instruccion;

  assign funct3_p0 = instruccion[14:12];
  assign funct7_p0 = instruccion[31:25];

  // The funct fields are only examined for R-type and I-type classes, so an
  // unknown instruction word cannot leak through for load/store or branch.
  function automatic logic [1:0] decode_sel(input logic [1:0] op,
                                            input logic [6:0] f7,
                                            input logic [2:0] f3);
    logic [1:0] sel;
    sel = SEL_ADD;
    case (op)
      OP_MEM:    sel = SEL_ADD;
      OP_BRANCH: sel = SEL_SUB;
      OP_RTYPE: begin
        case ({f7, f3})
          {F7_BASE, F3_ADD}: sel = SEL_ADD;
          {F7_ALT,  F3_ADD}: sel = SEL_SUB;
          {F7_BASE, F3_AND}: sel = SEL_AND;
          {F7_BASE, F3_OR }: sel = SEL_OR;
          default:           sel = SEL_ADD;
        endcase
      end
      OP_ITYPE: begin
        // No immediate SUB exists, so funct7 is not consulted here.
        case (f3)
          F3_AND:  sel = SEL_AND;
          F3_OR:   sel = SEL_OR;
          default: sel = SEL_ADD;
        endcase
      end
      default: sel = SEL_ADD;
    endcase
    return sel;
  endfunction

  assign sel_p0 = decode_sel(ALU_OP, funct7_p0, funct3_p0);

  // ---- stage p0 -> p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_inst_p1 <= SEL_ADD;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= valid_in;
      if (valid_in) begin
        alu_inst_p1 <= sel_p0;
      end
    end
  end

  assign alu_inst  = alu_inst_p1;
  assign valid_out = vld_p1;

`ifdef ALU_CONTROL_ILLEGAL_DET_EN
  logic ill_p0;
  logic ill_p1;

  function automatic logic decode_illegal(input logic [1:0] op,
                                          input logic [6:0] f7,
                                          input logic [2:0] f3);
    logic ill;
    ill = 1'b0;
    case (op)
      OP_RTYPE: begin
        case ({f7, f3})
          {F7_BASE, F3_ADD},
          {F7_ALT,  F3_ADD},
          {F7_BASE, F3_AND},
          {F7_BASE, F3_OR }: ill = 1'b0;
          default:           ill = 1'b1;
        endcase
      end
      OP_ITYPE: begin
        case (f3)
          F3_ADD, F3_AND, F3_OR: ill = 1'b0;
          default:               ill = 1'b1;
        endcase
      end
      default: ill = 1'b0;
    endcase
    return ill;
  endfunction

  assign ill_p0 = decode_illegal(ALU_OP, funct7_p0, funct3_p0);

  // ---- stage p0 -> p1: illegal flag register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ill_p1 <= 1'b0;
    end else if (valid_in) begin
      ill_p1 <= ill_p0;
    end
  end

  assign illegal = ill_p1;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control.sv
module tb_alu_control;

  logic        clk;
  logic        rst;
  logic [31:0] instruccion;
  logic [1:0]  ALU_OP;
  logic        valid_in;
  logic [1:0]  alu_inst;
  logic        valid_out;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference-model state: what the outputs should show after the last edge.
  logic [1:0] exp_sel;
  logic       exp_ill;
  logic       exp_vld;

  alu_control #(.width_instruc(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruccion (instruccion),
    .ALU_OP      (ALU_OP),
    .valid_in    (valid_in),
    .alu_inst    (alu_inst),
    .valid_out   (valid_out),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Supported encodings as lookup tables: {funct7, funct3, result}.
  int r_f7 [4] = '{0, 32, 0, 0};
  int r_f3 [4] = '{0, 0, 7, 6};
  int r_res[4] = '{0, 1, 2, 3};
  int i_f3 [3] = '{0, 7, 6};
  int i_res[3] = '{0, 2, 3};

  // Returns {illegal, select} for one decode.
  function automatic logic [2:0] ref_decode(input logic [1:0] op, input logic [31:0] ins);
    int f3;
    int f7;
    if (op == 2'd0) return 3'b000;
    if (op == 2'd1) return 3'b001;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    if (op == 2'd2) begin
      for (int k = 0; k < 4; k++)
        if (f7 == r_f7[k] && f3 == r_f3[k]) return {1'b0, 2'(r_res[k])};
      return 3'b100;
    end
    for (int k = 0; k < 3; k++)
      if (f3 == i_f3[k]) return {1'b0, 2'(i_res[k])};
    return 3'b100;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, let an edge occur, update the model, compare.
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [31:0] ins, input string tag);
    logic [2:0] d;
    rst = r;
    valid_in = v;
    ALU_OP = op;
    instruccion = ins;
    @(posedge clk);
    #1;
    if (r) begin
      exp_sel = 2'b00;
      exp_ill = 1'b0;
      exp_vld = 1'b0;
    end else begin
      exp_vld = v;
      if (v) begin
        d = ref_decode(op, ins);
        exp_sel = d[1:0];
`ifdef ALU_CONTROL_ILLEGAL_DET_EN
        exp_ill = d[2];
`else
        exp_ill = 1'b0;
`endif
      end
    end
    check({tag, "_sel"}, alu_inst, exp_sel);
    check({tag, "_ill"}, {1'b0, illegal}, {1'b0, exp_ill});
    check({tag, "_vld"}, {1'b0, valid_out}, {1'b0, exp_vld});
  endtask

  initial begin
    logic [31:0] rins;
    logic [6:0]  rf7;
    rst = 1'b1;
    valid_in = 1'b1;
    ALU_OP = 2'b00;
    instruccion = 32'h0;
    exp_sel = 2'b00;
    exp_ill = 1'b0;
    exp_vld = 1'b0;

    // Reset held with valid_in high
    step(1'b1, 1'b1, 2'b10, 32'h4000_7000, "rst1");
    step(1'b1, 1'b1, 2'b01, 32'h0, "rst2");

    // Load/store and branch classes
    step(1'b0, 1'b1, 2'b00, 32'h0, "mem_add");
    step(1'b0, 1'b1, 2'b01, 32'h0, "br_sub");

    // R-type
    step(1'b0, 1'b1, 2'b10, 32'h0000_0000, "r_add");
    step(1'b0, 1'b1, 2'b10, 32'h4000_0000, "r_sub");
    step(1'b0, 1'b1, 2'b10, 32'h0000_7000, "r_and");
    step(1'b0, 1'b1, 2'b10, 32'h0000_6000, "r_or");

    // I-type
    step(1'b0, 1'b1, 2'b11, 32'h4000_0000, "i_add_f7");
    step(1'b0, 1'b1, 2'b11, 32'h0000_7000, "i_and");
    step(1'b0, 1'b1, 2'b11, 32'h0000_1000, "i_ill");
    step(1'b0, 1'b1, 2'b11, 32'h0000_6000, "i_or");

    // Unsupported R-type combination
    step(1'b0, 1'b1, 2'b10, 32'h4000_7000, "r_ill");

    // SUB, then hold with valid_in low, then reset
    step(1'b0, 1'b1, 2'b10, 32'h4000_0000, "hold_sub");
    step(1'b0, 1'b0, 2'b00, 32'h0, "hold1");
    step(1'b0, 1'b0, 2'b00, 32'h0, "hold2");
    step(1'b0, 1'b0, 2'b00, 32'h0, "hold3");
    step(1'b1, 1'b0, 2'b00, 32'h0, "rst_mid");

    // Unknown instruction bits for classes that ignore them
    step(1'b0, 1'b1, 2'b00, 32'hxxxx_xxxx, "x_mem");
    step(1'b0, 1'b1, 2'b01, 32'hxxxx_xxxx, "x_br");

    // Illegal flag held while idle, then reset mid-stream
    step(1'b0, 1'b1, 2'b10, 32'h0000_1000, "ill_set");
    step(1'b0, 1'b0, 2'b10, 32'h0000_0000, "ill_hold");
    step(1'b1, 1'b1, 2'b10, 32'h0000_7000, "rst_pend");
    step(1'b0, 1'b1, 2'b10, 32'h0000_6000, "post_rst");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       rf7 = 7'h00;
        1:       rf7 = 7'h20;
        default: rf7 = 7'($urandom);
      endcase
      rins = $urandom;
      rins[31:25] = rf7;
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom), rins, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
